// File: rtl/onehot_decoder_stream.sv
// -----------------------------------------------------------------------------
// onehot_decoder_stream
//
// Streaming N-to-2^N decoder. Encoded bit indices arrive over a valid/ready
// handshake, are buffered in a 2-entry FIFO, and leave as reconstructed
// 2^IN_W-bit words over a second valid/ready handshake. A wrapping counter
// tracks how many words have been delivered since reset.
//
// Optional build macro: ONEHOT_DECODER_THERMO_EN
//   undefined : out_data is strictly one-hot, bit [head_idx] set.
//   defined   : out_data is a thermometer mask, bits [head_idx:0] set.
//   Handshake, FIFO, counter and reset behaviour are identical in both builds.
//
// Parameters:
//   IN_W   index width (output width OUT_W = 2**IN_W)
//   CNT_W  width of the delivered-word counter
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   in_valid    in_idx is valid this cycle
//   in_ready    block can accept an index this cycle
//   in_idx      encoded bit position, 0..OUT_W-1
//   out_valid   out_data holds a decoded word
//   out_ready   downstream accepts out_data this cycle
//   out_data    decoded word (zero when out_valid is low)
//   word_count  number of words delivered (pops) since reset, wraps
// -----------------------------------------------------------------------------
module onehot_decoder_stream #(
  parameter int IN_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**IN_W)-1:0]  out_data,
  output logic [CNT_W-1:0]      word_count
);

  localparam int OUT_W = 2 ** IN_W;

  // FIFO occupancy doubles as the control state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_t;

  fifo_state_t           r_state;
  logic [IN_W-1:0]       r_mem [2];
  logic                  r_head;
  logic                  r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  w_push;
  logic                  w_pop;
  logic [IN_W-1:0]       w_head_idx;
  logic [OUT_W-1:0]      w_word;

  // ---------------------------------------------------------------------------
  // Handshake. Both ready and valid come from registered state only, so there
  // is no combinational path from out_ready to in_ready. in_ready is also
  // forced low while reset is held.
  // ---------------------------------------------------------------------------
  assign in_ready  = !reset && (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Decode of the head entry.
  // ---------------------------------------------------------------------------
  assign w_head_idx = r_mem[r_head];

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the block can leave it unassigned and infer
    // a latch.
    w_word = '0;
    for (int i = 0; i < OUT_W; i++) begin
`ifdef ONEHOT_DECODER_THERMO_EN
      // Fill every bit at or below the head index.
      w_word[i] = (IN_W'(i) <= w_head_idx);
`else
      w_word[i] = (IN_W'(i) == w_head_idx);
`endif
    end
  end

  // Empty FIFO presents an all-zero word rather than a stale entry.
  assign out_data   = out_valid ? w_word : '0;
  assign word_count = r_count;

  // ---------------------------------------------------------------------------
  // FIFO storage, pointers, occupancy state and delivered-word counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the two storage entries are reset along with the control state
      // because they are architecturally visible as zero after reset; a deep
      // RAM would normally be left unreset and guarded by the valid state.
      r_state  <= ST_EMPTY;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_count  <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (w_push) begin
        r_mem[r_tail] <= in_idx;
        r_tail        <= ~r_tail;
      end

      if (w_pop) begin
        r_head  <= ~r_head;
        r_count <= r_count + CNT_W'(1);
      end

      case (r_state)
        ST_EMPTY: begin
          // pop cannot happen here because out_valid is low.
          if (w_push) r_state <= ST_ONE;
        end
        ST_ONE: begin
          // push and pop together: old head leaves, new entry becomes head,
          // occupancy is unchanged.
          if (w_push && !w_pop)      r_state <= ST_FULL;
          else if (w_pop && !w_push) r_state <= ST_EMPTY;
        end
        ST_FULL: begin
          // push cannot happen here because in_ready is low.
          if (w_pop) r_state <= ST_ONE;
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_decoder_stream.sv
module tb_onehot_decoder_stream;

  localparam int IN_W  = 3;
  localparam int OUT_W = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_idx = '0;
  logic             out_ready = 1'b0;

  logic             in_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] word_count;

  // Narrow-counter instance shares all inputs to exercise the wrap.
  logic             in_ready_c4;
  logic             out_valid_c4;
  logic [OUT_W-1:0] out_data_c4;
  logic [3:0]       word_count_c4;

  onehot_decoder_stream #(.IN_W(IN_W), .CNT_W(CNT_W)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .word_count (word_count)
  );

  onehot_decoder_stream #(.IN_W(IN_W), .CNT_W(4)) u_dut_c4 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready_c4),
    .in_idx     (in_idx),
    .out_valid  (out_valid_c4),
    .out_ready  (out_ready),
    .out_data   (out_data_c4),
    .word_count (word_count_c4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [OUT_W-1:0] exp_word(input logic [IN_W-1:0] idx);
    logic [OUT_W-1:0] w;
    w = '0;
`ifdef ONEHOT_DECODER_THERMO_EN
    for (int i = 0; i <= int'(idx); i++) w[i] = 1'b1;
`else
    w[idx] = 1'b1;
`endif
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard: reference FIFO of expected words, updated from the inputs and
  // its own occupancy, compared against the DUT on every falling edge.
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] sb_q[$];
  int unsigned      m_count = 0;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_in_ready",   in_ready,   0);
      check("rst_out_valid",  out_valid,  0);
      check("rst_out_data",   out_data,   0);
      check("rst_word_count", word_count, 0);
      sb_q.delete();
      m_count = 0;
    end else begin
      logic do_push;
      logic do_pop;
      do_push = in_valid && (sb_q.size() < 2);
      do_pop  = out_ready && (sb_q.size() != 0);
      check("in_ready",      in_ready,      (sb_q.size() < 2));
      check("out_valid",     out_valid,     (sb_q.size() != 0));
      check("out_data",      out_data,      (sb_q.size() != 0) ? sb_q[0] : '0);
      check("word_count",    word_count,    m_count & 32'hFFFF);
      check("word_count_c4", word_count_c4, m_count & 32'hF);
      if (do_pop) begin
        void'(sb_q.pop_front());
        m_count++;
      end
      if (do_push) sb_q.push_back(exp_word(in_idx));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Presents idx until accepted; leaves in_valid high for back-to-back use.
  task automatic send(input logic [IN_W-1:0] idx);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_idx   = idx;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = !out_valid;
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then single transfer.
    apply_reset();
    out_ready = 1'b1;
    send(3'd2);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_valid", out_valid, 1);
    check("t1_data",  out_data,  exp_word(3'd2));
    wait_drain();
    check("t1_count", word_count, 1);

    // Back-to-back streaming with in_ready held high.
    apply_reset();
    out_ready = 1'b1;
    send(3'd4);
    send(3'd7);
    send(3'd1);
    send(3'd0);
    in_valid = 1'b0;
    wait_drain();
    check("t2_count", word_count, 4);

    // Backpressure: fill, refuse a third index, then drain.
    apply_reset();
    send(3'd6);
    send(3'd3);
    in_idx = 3'd5;
    repeat (3) begin
      @(negedge clk);
      check("t3_full_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(3'd5);
    in_valid = 1'b0;
    wait_drain();
    check("t3_count", word_count, 3);

    // Simultaneous push and pop with one entry buffered.
    apply_reset();
    send(3'd1);
    out_ready = 1'b1;
    send(3'd7);
    in_valid = 1'b0;
    @(negedge clk);
    check("t4_valid", out_valid, 1);
    check("t4_data",  out_data,  exp_word(3'd7));
    wait_drain();
    check("t4_count", word_count, 2);

    // Asynchronous reset while FULL.
    apply_reset();
    out_ready = 1'b1;
    send(3'd4);
    in_valid = 1'b0;
    wait_drain();
    out_ready = 1'b0;
    send(3'd2);
    send(3'd5);
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_full_count", word_count, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t5_async_valid", out_valid,  0);
    check("t5_async_data",  out_data,   0);
    check("t5_async_count", word_count, 0);
    check("t5_async_ready", in_ready,   0);
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t5_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Counter wrap on the 4-bit instance after 17 pops.
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) send(IN_W'(k % OUT_W));
    in_valid = 1'b0;
    wait_drain();
    check("t6_count_c4",  word_count_c4, 1);
    check("t6_count_w16", word_count,    17);

    // Decode shape for idx 3 and idx 7 (one-hot or thermometer).
    apply_reset();
    send(3'd3);
    in_valid = 1'b0;
    @(negedge clk);
`ifdef ONEHOT_DECODER_THERMO_EN
    check("t7_idx3", out_data, 8'b0000_1111);
`else
    check("t7_idx3", out_data, 8'b0000_1000);
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(3'd7);
    in_valid = 1'b0;
    @(negedge clk);
`ifdef ONEHOT_DECODER_THERMO_EN
    check("t7_idx7", out_data, 8'b1111_1111);
`else
    check("t7_idx7", out_data, 8'b1000_0000);
`endif
    out_ready = 1'b1;
    wait_drain();
    check("t7_count", word_count, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_stream.md
Name: onehot_decoder_stream

Overview:
- Streaming N-to-2^N decoder; the decode-side partner of the team's 8-to-3 priority encoder.
- Accepts encoded bit indices over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Emits the reconstructed one-hot 8-bit word (default) over a second valid/ready handshake.
- Sits downstream of the priority encoder: turns an index stream back into request/grant vectors and counts words delivered.

Parameters:
- IN_W, 3, index width; output width OUT_W = 2**IN_W (derived localparam, 8 at default).
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_idx is valid this cycle.
- in_ready  output  1  block can accept an index this cycle.
- in_idx  input  IN_W  encoded bit position, 0..OUT_W-1.
- out_valid  output  1  out_data holds a decoded word.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  OUT_W  decoded word.
- word_count  output  CNT_W  number of words delivered (pops) since reset.

Behaviour:
- Reset: asynchronous, active-high. While reset is high, the following hold:
  - FIFO state = EMPTY, both entries = 0.
  - out_valid = 0, out_data = 0, word_count = 0, in_ready = 0.
  - in_ready rises the first cycle after reset deasserts.
- Reset asserted mid-transfer discards all buffered entries. No partial word is emitted afterwards.
- FIFO states:
  - EMPTY (0 entries), ONE (1 entry), FULL (2 entries).
  - Head pointer and tail pointer are 1 bit each.
- Handshake rules:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - in_ready = !reset && state != FULL. It is derived from registered state only; there is no combinational path from out_ready.
  - out_valid = state != EMPTY.
- State transitions:
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push and pop -> ONE (old head leaves, new entry becomes head).
  - FULL: pop -> ONE. Push cannot occur because in_ready = 0.
- Data path:
  - out_data = (1 << head_idx) when out_valid, else all-zero. This is combinational from the head register.
  - Exactly one bit is set whenever out_valid = 1 (default build).
- Latency:
  - An index pushed at clock edge k appears on out_data from edge k onward when the FIFO was EMPTY, i.e. it is visible in cycle k+1.
  - Otherwise it appears once all older entries have been popped.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- Stall: with out_ready low, out_data and out_valid stay stable until a pop. Inputs are ignored while in_ready = 0.
- word_count:
  - Increments by 1 on each pop and wraps modulo 2**CNT_W (0xFFFF -> 0x0000 at default).
  - Does not change on push.
- in_idx is always in range by construction (width IN_W), so there is no illegal-input case.

Optional Feature:
- Macro: ONEHOT_DECODER_THERMO_EN.
- Defined: out_data is a thermometer mask with bits [head_idx:0] set. Examples: idx 2 -> 00000111; idx 7 -> 11111111. This is the lowest-bits-filled vector whose priority-encoded value equals head_idx.
- Undefined: strict one-hot output as above.
- Handshake, FIFO, counter and reset behaviour are identical in both builds.

Test Plan:
- Reset, then single transfer:
  - Stimulus: hold reset 2 cycles; release; push idx=2 with out_ready=1.
  - Required: next cycle out_valid=1, out_data=00000100; after the pop, word_count=1 and out_valid=0.
- Back-to-back streaming:
  - Stimulus: out_ready=1; push idx 4,7,1,0 on consecutive cycles.
  - Required: out_data = 00010000, 10000000, 00000010, 00000001 on consecutive cycles; in_ready stays 1 throughout; word_count=4.
- Backpressure and full:
  - Stimulus: out_ready=0; push idx 6 then 3; attempt idx 5.
  - Required: in_ready=0 after the second push; idx 5 is not accepted.
  - Then set out_ready=1 and re-present idx 5. Required: outputs 01000000, 00001000, 00100000 in order; word_count=3.
- Simultaneous push and pop in ONE:
  - Stimulus: with one entry (idx 1) buffered and out_ready=1, push idx 7 in the same cycle.
  - Required: state stays ONE; next out_data=10000000.
- Reset mid-operation:
  - Stimulus: FULL with idx 2,5; assert reset asynchronously between clock edges.
  - Required: out_valid and out_data drop to 0 immediately, word_count=0; after release, no stale words appear.
- Counter wrap and THERMO build:
  - Stimulus: CNT_W=4; perform 17 pops.
  - Required: word_count reads 1.
  - With ONEHOT_DECODER_THERMO_EN defined, required: idx 3 -> out_data=00001111.
